// File: rtl/modu_sweep_ctrl.sv
// Exhaustive 64-vector sweep sequencer for the modu block: drives {D,C,B,A},
// holds each vector SETTLE_CYCLES cycles, folds F into a rotate-xor signature.
module modu_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SIG_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic [2:0]       F,
  output logic             A,
  output logic             B,
  output logic [1:0]       C,
  output logic [1:0]       D,
  output logic [5:0]       vec_idx,
  output logic             sample_stb,
  output logic [SIG_W-1:0] sig,
  output logic             busy,
  output logic             done,
  output logic             pass
);
  localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [5:0]       vec_q, vec_d;
  logic [SIG_W-1:0] sig_q, sig_d, sig_nxt;
  logic             done_q, done_d, pass_q, pass_d;

  assign sig_nxt = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(F);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    sig_d      = sig_q;
    done_d     = done_q;
    pass_d     = pass_q;
    sample_stb = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          vec_d   = '0;
          sig_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          vec_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (!hold) begin
          if (cnt_q == CNT_LAST) begin
            sample_stb = 1'b1;
            sig_d      = sig_nxt;
            cnt_d      = '0;
            if (vec_q == 6'd63) begin
              // exp_sig only matters on this final edge
              state_d = S_DONE;
              vec_d   = '0;
              done_d  = 1'b1;
              pass_d  = (sig_nxt == exp_sig);
            end else begin
              vec_d = vec_q + 6'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          vec_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          vec_d   = '0;
          sig_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      sig_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign {D, C, B, A} = vec_q;
  assign vec_idx      = vec_q;
  assign sig          = sig_q;
  assign busy         = (state_q == S_RUN);
  assign done         = done_q;
  assign pass         = pass_q;
endmodule

// File: tb/tb_modu_sweep_ctrl.sv
// Randomized bench for modu_sweep_ctrl: a table-driven modu stand-in feeds F,
// and a sample-count signature model predicts every cycle of each sweep.
module tb_modu_sweep_ctrl;
  localparam int S  = 2;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, hold;
  logic [SW-1:0] exp_sig;
  logic [2:0]    F;
  logic          A, B, sample_stb, busy, done, pass;
  logic [1:0]    C, D;
  logic [5:0]    vec_idx;
  logic [SW-1:0] sig;

  int         checks = 0, failures = 0;
  int         fmode  = 0;
  logic [2:0] lut [64];

  modu_sweep_ctrl #(.SETTLE_CYCLES(S), .SIG_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
    .exp_sig(exp_sig), .F(F), .A(A), .B(B), .C(C), .D(D), .vec_idx(vec_idx),
    .sample_stb(sample_stb), .sig(sig), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  always_comb begin
    F = 3'b000;
    if (fmode == 0)      F = lut[{D, C, B, A}];
    else if (fmode == 1) F = 3'b001;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] fval(input int v);
    if (fmode == 0) return lut[v];
    if (fmode == 1) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [SW-1:0] sig_after(input int n);
    logic [SW-1:0] m = '0;
    for (int i = 0; i < n; i++) m = ((m << 1) | (m >> (SW - 1))) ^ SW'(fval(i));
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep from IDLE/DONE, checked every cycle against elapsed-cycle arithmetic.
  task automatic run_sweep(input int hold_at, input int hold_len, input bit spam,
                           input logic [SW-1:0] es);
    int k = 0, hc = 0, e = 0;
    logic [SW-1:0] m = '0;
    exp_sig = es;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (k < 64 * S && e < 64 * S + hold_len + 8) begin
      hold  = (k == hold_at * S) && (hc < hold_len);
      start = spam && ($urandom_range(0, 3) == 0);
      #1;
      chk("vec", vec_idx, k / S);
      chk("abcd", {D, C, B, A}, k / S);
      chk("sig", sig, m);
      chk("busy", busy, 1);
      chk("done_run", done, 0);
      chk("stb", sample_stb, !hold && (k % S == S - 1));
      if (fmode == 1 && k == 16 * S) chk("sig16", sig, 16'hFFFF);
      if (fmode == 1 && k == 24 * S) chk("sig24", sig, 16'hFF00);
      if (!hold) begin
        if (k % S == S - 1) m = ((m << 1) | (m >> (SW - 1))) ^ SW'(fval(k / S));
        k++;
      end else begin
        hc++;
      end
      tick();
      e++;
    end
    hold  = 1'b0;
    start = 1'b0;
    chk("latency", e, 64 * S + hold_len);
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("sig_final", sig, m);
    chk("pass", pass, m == es);
    chk("vec_done", vec_idx, 0);
    exp_sig = ~es;
    tick();
    chk("done_hold", done, 1);
    chk("pass_hold", pass, m == es);
    chk("sig_hold", sig, m);
    chk("abcd_done", {D, C, B, A}, 0);
    chk("stb_done", sample_stb, 0);
  endtask

  task automatic wait_vec(input int v);
    for (int i = 0; i < 200 && vec_idx != 6'(v); i++) tick();
    chk("reach_vec", vec_idx, v);
  endtask

  initial begin
    logic [SW-1:0] s;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; exp_sig = '0;
    for (int i = 0; i < 64; i++) lut[i] = 3'($urandom);
    tick();
    tick();
    chk("rst_vec", vec_idx, 0);
    chk("rst_abcd", {D, C, B, A}, 0);
    chk("rst_sig", sig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_stb", sample_stb, 0);
    rst_n = 1'b1;
    hold  = 1'b1;
    tick();
    chk("hold_idle", busy, 0);
    hold = 1'b0;

    fmode = 0;
    run_sweep(-1, 0, 1'b0, sig_after(64));
    run_sweep(-1, 0, 1'b1, sig_after(64) ^ 16'h0001);
    run_sweep(10, 5, 1'b0, sig_after(64));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 64; i++) lut[i] = 3'($urandom);
      run_sweep($urandom_range(1, 62), $urandom_range(1, 6), 1'b1, sig_after(64));
    end

    fmode = 1;
    run_sweep(-1, 0, 1'b0, 16'h0000);
    run_sweep(-1, 0, 1'b0, 16'h0001);
    fmode = 2;
    run_sweep(-1, 0, 1'b0, 16'h0000);
    run_sweep(-1, 0, 1'b0, 16'($urandom_range(1, 65535)));

    // abort and start together mid-sweep
    fmode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_vec(30);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_vec", vec_idx, 0);
    chk("abort_sig", sig, sig_after(30));
    tick();
    chk("abort_idle", busy, 0);

    // abort in DONE, then abort in IDLE
    s = sig_after(64);
    run_sweep(-1, 0, 1'b0, s);
    abort = 1'b1;
    tick();
    chk("abort_d_done", done, 0);
    chk("abort_d_pass", pass, 0);
    chk("abort_d_sig", sig, s);
    tick();
    abort = 1'b0;
    chk("abort_idle_sig", sig, s);
    chk("abort_idle_busy", busy, 0);

    // asynchronous reset mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_vec(20);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vec", vec_idx, 0);
    chk("mrst_abcd", {D, C, B, A}, 0);
    chk("mrst_sig", sig, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_pass", pass, 0);
    chk("mrst_stb", sample_stb, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep(-1, 0, 1'b0, sig_after(64));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/modu_sweep_ctrl.md
# modu_sweep_ctrl

Exhaustive-sweep sequencer for the `modu` combinational block (inputs A, B 1-bit; C, D 2-bit; output F 3-bit). On a start pulse it drives all 64 input combinations in fixed order and holds each vector for a programmable settle time. It samples F at the end of each vector and folds the samples into a running signature. It ends with a done/pass report against an expected signature. It sits between the test/control register bank and a `modu` instance, and replaces open-loop stimulus with a self-checking hardware sweep.

## Interface
- SETTLE_CYCLES, 2, cycles each vector is held before F is sampled; legal range ≥1.
- SIG_W, 16, signature width; legal range ≥3.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep.
- abort  in  1  terminates a sweep and returns to IDLE.
- hold  in  1  freezes the sweep while high.
- exp_sig  in  SIG_W  expected final signature.
- F  in  3  output of the `modu` block being swept.
- A  out  1  drive to `modu` A.
- B  out  1  drive to `modu` B.
- C  out  2  drive to `modu` C.
- D  out  2  drive to `modu` D.
- vec_idx  out  6  current vector index; {D,C,B,A} = vec_idx.
- sample_stb  out  1  high in the cycle at whose end F is captured.
- sig  out  SIG_W  running signature register, always visible.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; high when sig == exp_sig.

## Operation
- States: IDLE, RUN, DONE.
- Vector order: vec_idx runs 0..63, so A toggles fastest, then B, then C, then D. A/B/C/D are taken directly from the vec_idx register.
- IDLE → RUN on start. At that edge: vec_idx=0, settle counter=0, sig=0, done=0, pass=0.
- RUN, hold=0: the counter increments each cycle. When counter == SETTLE_CYCLES-1:
  - sample_stb=1 (combinational).
  - At that edge: sig ← rotl(sig,1) ^ zero-extend(F); counter ← 0.
  - If vec_idx<63: vec_idx ← vec_idx+1.
  - If vec_idx==63: go to DONE, vec_idx ← 0, done ← 1, pass ← (new sig == exp_sig). exp_sig is sampled on this edge only.
- RUN, hold=1: counter, vec_idx and sig are frozen; sample_stb=0; outputs keep their current vector.
- DONE: sig and pass are held; outputs stay 0. start → RUN, with the same initialisation as from IDLE.
- abort while in RUN or DONE → IDLE at the next edge: vec_idx=0, done=0, pass=0, sig kept. abort in IDLE has no effect.
- Priority: abort > start, and abort > hold. start during RUN is ignored. hold outside RUN is ignored.
- Counter width is clog2(SETTLE_CYCLES), minimum 1 bit. With SETTLE_CYCLES=1, sample_stb is high every RUN cycle.

## Timing
- Reset values: state IDLE, A=B=0, C=D=0, vec_idx=0, sig=0, sample_stb=0, busy=0, done=0, pass=0. Reset takes effect immediately and asynchronously, including mid-sweep.
- start is registered. The first vector (0) appears the cycle after the start edge. Latency from the start edge to done=1 is exactly 64×SETTLE_CYCLES edges, plus one edge per cycle with hold=1 in RUN.
- Each vector is stable for exactly SETTLE_CYCLES cycles when hold=0. F must be settled by the end of the last of those cycles.
- All outputs are registered except sample_stb.
- done and pass are levels. They stay set until start, abort or reset.

## Test plan
- Reset mid-sweep: pulse rst_n low at vec_idx=20 → all outputs 0 at once, busy=0; after release, start runs a full, correct sweep.
- Order and timing: SETTLE_CYCLES=2, real `modu` model → vec_idx steps 0..63, each value held 2 cycles, {D,C,B,A}==vec_idx throughout. done rises 128 edges after the start edge and pass=1 when exp_sig = model signature.
- Signature arithmetic: F tied to 3'b001, SETTLE_CYCLES=1 → sig=0xFFFF after 16 samples, 0xFF00 after 24, 0x0000 after 64. exp_sig=0x0000 → pass=1; exp_sig=0x0001 → pass=0.
- Hold: assert hold for 5 cycles at vec_idx=10 → vec_idx, sig and outputs frozen, sample_stb=0; done is delayed by exactly 5 cycles and the final sig is unchanged.
- Abort/start precedence: abort and start together at vec_idx=30 → IDLE, done=0; start in RUN ignored (vec_idx continues); start in DONE restarts with sig cleared to 0.
- Tie-off: F tied to 3'b000 → final sig=0x0000; pass follows exp_sig==0.
